// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
//
// Multi-cycle main controller for the MIPS datapath. Each instruction walks
// through FETCH -> DECODE -> (execute / memory) -> writeback, and the control
// lines for the shared memory, IR, PC, ALU and register file are decoded from
// the registered state (Moore). The only input-dependent outputs are:
//   - the FETCH IR/PC load and the MEMWR retire, which follow memory readiness;
//   - the illegal pulse in DECODE, which follows the live opcode.
//
// Memory handshake: a memory access (FETCH, MEMRD, MEMWR) holds its strobe
// high and stays in its state until the cycle where rdy is high. That cycle
// completes the access and the state advances on the next rising edge.
// rdy = mem_ready, or constant 1 when USE_READY = 0.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   opcode[5:0]      IR[31:26], valid from DECODE onward
//   mem_ready        memory access completes this cycle
//   pc_write         unconditional PC load
//   pc_write_cond    PC load when ALU zero (branch)
//   pc_src[1:0]      00 ALU result, 01 ALUOut, 10 jump target
//   iord             memory address: 0 PC, 1 ALUOut
//   mem_read         memory read strobe
//   mem_write        memory write strobe
//   ir_write         IR load
//   reg_dst          destination: 1 rd, 0 rt
//   reg_write        register-file write enable
//   mem_to_reg       writeback data: 1 MDR, 0 ALUOut
//   alu_src_a        A operand: 0 PC, 1 register A
//   alu_src_b[1:0]   B operand: 00 B, 01 const 4, 10 sign-ext imm, 11 imm<<2
//   alu_op           ALU operation code, zero-extended to ALUOP_W
//   state_out[3:0]   current state encoding (debug)
//   illegal          one-cycle pulse: undefined opcode decoded
//   retire           one-cycle pulse: instruction completes
//   instr_count      retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module mc_control_fsm #(
    parameter int ALUOP_W   = 5,
    parameter int USE_READY = 1,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pc_write,
    output logic               pc_write_cond,
    output logic [1:0]         pc_src,
    output logic               iord,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [ALUOP_W-1:0] alu_op,
    output logic [3:0]         state_out,
    output logic               illegal,
    output logic               retire,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_IEXEC  = 4'd8,
        S_IWB    = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SEQ   = 6'b011000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // ALU operation codes (5-bit, zero-extended onto alu_op)
    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_RTYPE = 5'b00010;
    localparam logic [4:0] ALU_ADDI  = 5'b00011;
    localparam logic [4:0] ALU_ANDI  = 5'b00100;
    localparam logic [4:0] ALU_ORI   = 5'b00101;
    localparam logic [4:0] ALU_XORI  = 5'b00110;
    localparam logic [4:0] ALU_SLTI  = 5'b00111;
    localparam logic [4:0] ALU_SEQ   = 5'b01000;
    localparam logic [4:0] ALU_NOP   = 5'b01111;

    state_t           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic       rdy;
    logic [4:0] alu_code;
    // Raw (pre-reset-mask) versions of the enables that reset must silence
    logic       pc_write_raw, pc_write_cond_raw, ir_write_raw;
    logic       mem_read_raw, mem_write_raw, reg_write_raw;
    logic       illegal_raw, retire_raw;

    assign rdy = mem_ready | (USE_READY == 0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        pc_write_raw      = 1'b0;
        pc_write_cond_raw = 1'b0;
        pc_src            = 2'b00;
        iord              = 1'b0;
        mem_read_raw      = 1'b0;
        mem_write_raw     = 1'b0;
        ir_write_raw      = 1'b0;
        reg_dst           = 1'b0;
        reg_write_raw     = 1'b0;
        mem_to_reg        = 1'b0;
        alu_src_a         = 1'b0;
        alu_src_b         = 2'b00;
        alu_code          = ALU_ADD;
        illegal_raw       = 1'b0;
        retire_raw        = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read_raw = 1'b1;
                alu_src_b    = 2'b01;
                ir_write_raw = rdy;
                pc_write_raw = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                // op_q holds the opcode for the execute states so that a
                // changing IR bus cannot disturb them.
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SEQ:
                                  state_d = S_IEXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                state_d   = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_read_raw = 1'b1;
                iord         = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                state_d       = S_FETCH;
                retire_raw    = 1'b1;
            end
            S_MEMWR: begin
                // Strobe held through every wait cycle.
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (rdy) begin
                    state_d    = S_FETCH;
                    retire_raw = 1'b1;
                end
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_code  = ALU_RTYPE;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                state_d       = S_FETCH;
                retire_raw    = 1'b1;
            end
            S_IEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q)
                    OP_ADDI: alu_code = ALU_ADDI;
                    OP_ANDI: alu_code = ALU_ANDI;
                    OP_ORI:  alu_code = ALU_ORI;
                    OP_XORI: alu_code = ALU_XORI;
                    OP_SLTI: alu_code = ALU_SLTI;
                    OP_SEQ:  alu_code = ALU_SEQ;
                    default: alu_code = ALU_ADD;
                endcase
                state_d = S_IWB;
            end
            S_IWB: begin
                reg_write_raw = 1'b1;
                state_d       = S_FETCH;
                retire_raw    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a         = 1'b1;
                alu_code          = ALU_SUB;
                pc_write_cond_raw = 1'b1;
                pc_src            = 2'b01;
                state_d           = S_FETCH;
                retire_raw        = 1'b1;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                pc_src       = 2'b10;
                state_d      = S_FETCH;
                retire_raw   = 1'b1;
            end
            default: begin
                // Unused encodings 12-15: park the ALU and recover to FETCH.
                alu_code = ALU_NOP;
                state_d  = S_FETCH;
            end
        endcase

        count_d = count_q + {{(CNT_W-1){1'b0}}, retire_raw};
    end

    // Reset silences every enable and pulse so an aborted instruction
    // leaves no side effect behind.
    assign pc_write      = pc_write_raw      & ~rst;
    assign pc_write_cond = pc_write_cond_raw & ~rst;
    assign ir_write      = ir_write_raw      & ~rst;
    assign mem_read      = mem_read_raw      & ~rst;
    assign mem_write     = mem_write_raw     & ~rst;
    assign reg_write     = reg_write_raw     & ~rst;
    assign illegal       = illegal_raw       & ~rst;
    assign retire        = retire_raw        & ~rst;

    assign alu_op      = ALUOP_W'(alu_code);
    assign state_out   = state_q;
    assign instr_count = count_q;

endmodule
